// File: rtl/mult_div_pkg.sv
// Shared encodings for the multiply/divide sequencer and its decoder.
package mult_div_pkg;

    // Matches func 0x18..0x1B with the upper bits dropped.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam int                CNT_W     = 5;
    localparam logic [CNT_W-1:0]  LAST_STEP = 5'd31;

endpackage

// File: rtl/mult_div_seq_if.sv
// Request/result bundle between the control unit and the mult/div sequencer.
interface mult_div_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b,
                    input  busy, done, div_zero, hi, lo);
    modport slave  (input  start, op, a, b,
                    output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mult_div_seq.sv
// Iterative radix-2 multiply/divide with HI/LO ownership.
//
//   state  | meaning
//   S_IDLE | waiting for start; hi/lo hold last result
//   S_CALC | one shift-add or restoring step per cycle, 32 steps
//   S_FIX  | sign correction, hi/lo written on exit
//   S_DONE | one-cycle done pulse, back to idle
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    mult_div_seq_if.slave bus
);

    state_e               r_state;
    logic [CNT_W-1:0]     r_count;
    logic                 r_is_div;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_operand;
    logic                 r_neg_lo;
    logic                 r_neg_hi;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_div_zero;

    logic                 w_is_div;
    logic                 w_sign_a;
    logic                 w_sign_b;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_rem_sh;
    logic                 w_fits;
    logic [WIDTH-1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_prod_neg;
    logic [WIDTH-1:0]     w_quot_neg;
    logic [WIDTH-1:0]     w_rem_neg;

    // Operand magnitudes; -0x80000000 wraps to itself, which is the right magnitude.
    assign w_is_div = bus.op[1];
    assign w_sign_a = ~bus.op[0] & bus.a[WIDTH-1];
    assign w_sign_b = ~bus.op[0] & bus.b[WIDTH-1];
    assign w_mag_a  = w_sign_a ? -bus.a : bus.a;
    assign w_mag_b  = w_sign_b ? -bus.b : bus.b;

    // Multiply adds into the upper half with carry out; divide compares the
    // shifted 33-bit remainder so divisors above 2^31 still work.
    assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_operand};
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_fits     = w_rem_sh >= {1'b0, r_operand};
    assign w_diff     = w_rem_sh[WIDTH-1:0] - r_operand;
    assign w_prod_neg = -r_acc;
    assign w_quot_neg = -r_acc[WIDTH-1:0];
    assign w_rem_neg  = -r_acc[2*WIDTH-1:WIDTH];

    // Sequencer FSM, datapath and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_acc      <= '0;
            r_operand  <= '0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_is_div && (bus.b == '0)) begin
                            r_div_zero <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_div_zero <= 1'b0;
                            r_is_div   <= w_is_div;
                            r_count    <= '0;
                            r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                            r_operand  <= w_is_div ? w_mag_b : w_mag_a;
                            r_neg_lo   <= w_sign_a ^ w_sign_b;
                            r_neg_hi   <= w_is_div ? w_sign_a : (w_sign_a ^ w_sign_b);
                            r_state    <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (r_is_div) begin
                        r_acc <= w_fits ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                                        : {r_acc[2*WIDTH-2:0], 1'b0};
                    end else begin
                        r_acc <= r_acc[0] ? {w_add, r_acc[WIDTH-1:1]}
                                          : {1'b0, r_acc[2*WIDTH-1:1]};
                    end
                    if (r_count == LAST_STEP) begin
                        r_state <= S_FIX;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_lo <= r_neg_lo ? w_quot_neg : r_acc[WIDTH-1:0];
                        r_hi <= r_neg_hi ? w_rem_neg  : r_acc[2*WIDTH-1:WIDTH];
                    end else begin
                        r_lo <= r_neg_lo ? w_prod_neg[WIDTH-1:0]       : r_acc[WIDTH-1:0];
                        r_hi <= r_neg_lo ? w_prod_neg[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (r_state == S_CALC) || (r_state == S_FIX);
    assign bus.done     = (r_state == S_DONE);
    assign bus.div_zero = r_div_zero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;

endmodule

// File: tb/tb_mult_div_seq.sv
// Bench for mult_div_seq: fixed vectors, random ops against a plain
// arithmetic model, and hand sequences for div-by-zero, reset and start spam.
module tb_mult_div_seq;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mult_div_seq_if #(.WIDTH(32)) ifc ();

    mult_div_seq #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; returns {div_zero, hi, lo}.
    function automatic logic [64:0] ref_calc(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] ph,
                                             input logic [31:0] pl);
        longint      sq;
        longint      sr;
        logic [63:0] p;
        case (op)
            2'b00: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                return {1'b0, p};
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            2'b10: begin
                if (b == 0) return {1'b1, ph, pl};
                sq = longint'($signed(a)) / longint'($signed(b));
                sr = longint'($signed(a)) % longint'($signed(b));
                return {1'b0, sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, ph, pl};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Issue one op, then watch 40 cycles after the accept edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit spam, output logic [31:0] hi, output logic [31:0] lo,
                          output logic dz, output int lat, output int busy_cnt,
                          output int done_cnt);
        @(negedge clock);
        ifc.start = 1'b1;
        ifc.op    = op;
        ifc.a     = a;
        ifc.b     = b;
        @(posedge clock);
        lat = -1; busy_cnt = 0; done_cnt = 0;
        hi = '0; lo = '0; dz = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (ifc.busy) busy_cnt++;
            if (ifc.done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = k;
                    hi  = ifc.hi;
                    lo  = ifc.lo;
                    dz  = ifc.div_zero;
                end
            end
            if (spam && (ifc.busy || ifc.done)) begin
                ifc.start = 1'b1;
                ifc.op    = 2'($urandom);
                ifc.a     = $urandom;
                ifc.b     = $urandom;
            end else begin
                ifc.start = 1'b0;
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit spam);
        logic [31:0] hi, lo;
        logic        dz;
        int          lat, bc, dc;
        logic [64:0] r;
        r = ref_calc(op, a, b, model_hi, model_lo);
        run_op(op, a, b, spam, hi, lo, dz, lat, bc, dc);
        chk({tag, " hi"},       64'(hi),  64'(r[63:32]));
        chk({tag, " lo"},       64'(lo),  64'(r[31:0]));
        chk({tag, " div_zero"}, 64'(dz),  64'(r[64]));
        chk({tag, " latency"},  64'(lat), r[64] ? 64'd0 : 64'd33);
        chk({tag, " busy_cyc"}, 64'(bc),  r[64] ? 64'd0 : 64'd33);
        chk({tag, " done_cnt"}, 64'(dc),  64'd1);
        model_hi = r[63:32];
        model_lo = r[31:0];
    endtask

    initial begin
        logic [31:0] hi, lo;
        logic        dz;
        int          lat, bc, dc;
        logic [31:0] ra, rb;
        logic [1:0]  rop;

        vecs[0] = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4] = '{2'b01, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0};
        vecs[5] = '{2'b11, 32'h00000009, 32'h00000000, 32'h00000000, 32'h0000000F, 1'b1};
        vecs[6] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[7] = '{2'b11, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'h00000001, 1'b0};
        vecs[8] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[9] = '{2'b10, 32'h00000000, 32'h00000000, 32'h40000000, 32'h00000000, 1'b1};

        ifc.start = 1'b0;
        ifc.op    = 2'b00;
        ifc.a     = '0;
        ifc.b     = '0;
        reset     = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst busy",     64'(ifc.busy),     64'd0);
        chk("rst done",     64'(ifc.done),     64'd0);
        chk("rst div_zero", 64'(ifc.div_zero), 64'd0);
        chk("rst hi",       64'(ifc.hi),       64'd0);
        chk("rst lo",       64'(ifc.lo),       64'd0);
        reset = 1'b0;

        // Fixed vectors
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, hi, lo, dz, lat, bc, dc);
            chk($sformatf("vec%0d hi", i),       64'(hi),  64'(vecs[i].hi));
            chk($sformatf("vec%0d lo", i),       64'(lo),  64'(vecs[i].lo));
            chk($sformatf("vec%0d div_zero", i), 64'(dz),  64'(vecs[i].dz));
            chk($sformatf("vec%0d latency", i),  64'(lat), vecs[i].dz ? 64'd0 : 64'd33);
            chk($sformatf("vec%0d busy_cyc", i), 64'(bc),  vecs[i].dz ? 64'd0 : 64'd33);
            chk($sformatf("vec%0d done_cnt", i), 64'(dc),  64'd1);
        end
        model_hi = vecs[9].hi;
        model_lo = vecs[9].lo;

        // Random ops against the model
        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_and_check($sformatf("rnd%0d", i), rop, ra, rb, 1'b0);
        end

        // Start spammed through busy and done must be ignored
        run_and_check("spam", 2'b00, 32'h12345678, 32'hFEDCBA98, 1'b1);
        repeat (2) @(negedge clock);
        chk("spam idle busy", 64'(ifc.busy), 64'd0);

        // Reset during CALC, with start raised alongside reset
        @(negedge clock);
        ifc.start = 1'b1; ifc.op = 2'b00; ifc.a = 32'h0000ABCD; ifc.b = 32'h00001234;
        @(posedge clock);
        repeat (11) @(negedge clock);
        ifc.start = 1'b1; ifc.op = 2'b01; ifc.a = 32'd5; ifc.b = 32'd6;
        reset = 1'b1;
        @(negedge clock);
        chk("midrst busy",     64'(ifc.busy),     64'd0);
        chk("midrst done",     64'(ifc.done),     64'd0);
        chk("midrst div_zero", 64'(ifc.div_zero), 64'd0);
        chk("midrst hi",       64'(ifc.hi),       64'd0);
        chk("midrst lo",       64'(ifc.lo),       64'd0);
        reset = 1'b0;
        ifc.start = 1'b0;
        dc = 0; bc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (ifc.done) dc++;
            if (ifc.busy) bc++;
        end
        chk("midrst stray done", 64'(dc), 64'd0);
        chk("midrst stray busy", 64'(bc), 64'd0);
        model_hi = '0;
        model_lo = '0;
        run_and_check("divu100_7", 2'b11, 32'd100, 32'd7, 1'b0);
        chk("divu100_7 lo const", 64'(model_lo), 64'd14);
        chk("divu100_7 hi const", 64'(model_hi), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
